// File: rtl/fnd_scan_controller.sv
// Scan controller for a 4-digit common-anode 7-segment display.
// It steps through the digits one slot at a time. Each slot begins with a short
// blanking gap to prevent ghosting. The 16-bit BCD value is captured once per
// frame, and leading zeros can optionally be suppressed.
module fnd_scan_controller #(
  parameter int DIV       = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int CNT_W     = $clog2(DIV)
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_en,
  input  logic [15:0] i_value,
  input  logic [3:0]  i_dp,
  input  logic        i_blank_lz,
  output logic [1:0]  o_digitSelect,
  output logic        o_fnd_en,
  output logic [3:0]  o_bcd,
  output logic        o_dp,
  output logic        o_frame
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] BLANK = 2'd1;
  localparam logic [1:0] SHOW  = 2'd2;

  // A slot opens in BLANK unless the gap is configured away.
  localparam logic [1:0] SLOT_START = (BLANK_CYC == 0) ? SHOW : BLANK;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYC == 0) ? 0 : BLANK_CYC - 1);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [1:0]       digit;
  logic [15:0]      snap_val;
  logic [3:0]       snap_dp;
  logic             snap_lz;
  logic             frame;

  // Returns 1 when digit d is a leading zero that should stay dark.
  // A requested decimal point keeps the digit visible.
  function automatic logic lz_suppress(input logic [1:0]  d,
                                       input logic [15:0] v,
                                       input logic [3:0]  dpv,
                                       input logic        lz);
    logic upper_zero;
    case (d)
      2'd1:    upper_zero = (v[15:4]  == 12'd0);
      2'd2:    upper_zero = (v[15:8]  == 8'd0);
      2'd3:    upper_zero = (v[15:12] == 4'd0);
      default: upper_zero = 1'b0;
    endcase
    return lz && upper_zero && !dpv[d];
  endfunction

  // Scan FSM: prescaler, digit index, per-frame snapshot and frame pulse.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state    <= IDLE;
      cnt      <= '0;
      digit    <= 2'd0;
      snap_val <= 16'd0;
      snap_dp  <= 4'd0;
      snap_lz  <= 1'b0;
      frame    <= 1'b0;
    end else if (!i_en) begin
      // Abandon the current slot; the snapshot stays so o_bcd/o_dp keep digit 0.
      state <= IDLE;
      cnt   <= '0;
      digit <= 2'd0;
      frame <= 1'b0;
    end else begin
      frame <= 1'b0;
      case (state)
        IDLE: begin
          snap_val <= i_value;
          snap_dp  <= i_dp;
          snap_lz  <= i_blank_lz;
          cnt      <= '0;
          digit    <= 2'd0;
          frame    <= 1'b1;
          state    <= SLOT_START;
        end
        default: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            digit <= digit + 2'd1;
            state <= SLOT_START;
            // Wrapping back to digit 0 starts a new frame with fresh data.
            if (digit == 2'd3) begin
              snap_val <= i_value;
              snap_dp  <= i_dp;
              snap_lz  <= i_blank_lz;
              frame    <= 1'b1;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
            if (state == BLANK && cnt == BLANK_LAST) begin
              state <= SHOW;
            end
          end
        end
      endcase
    end
  end

  // Outputs are decoded from registers only, with no input-to-output path.
  always_comb begin
    o_digitSelect = digit;
    o_bcd         = snap_val[{digit, 2'b00} +: 4];
    o_dp          = snap_dp[digit];
    o_fnd_en      = (state == SHOW) && !lz_suppress(digit, snap_val, snap_dp, snap_lz);
    o_frame       = frame;
  end

endmodule

// File: tb/tb_fnd_scan_controller.sv
// Bench for fnd_scan_controller. Two builds run side by side on the same inputs:
// one with DIV=8, BLANK_CYC=2 and one with DIV=8, BLANK_CYC=0.
// A frame-time reference model checks every cycle, and directed checks are added
// around each feature.
module tb_fnd_scan_controller;

  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [15:0] value;
  logic [3:0]  dp;
  logic        lz;

  logic [1:0] sel_a, sel_b;
  logic       fen_a, fen_b;
  logic [3:0] bcd_a, bcd_b;
  logic       dp_a, dp_b;
  logic       frm_a, frm_b;

  int errors = 0;
  int checks = 0;

  // Reference model state: cycles since the enabling edge, plus the snapshot.
  bit          m_active;
  int          m_k;
  logic [15:0] m_val;
  logic [3:0]  m_dp;
  logic        m_lz;

  always #5 clk = ~clk;

  fnd_scan_controller #(.DIV(DIV), .BLANK_CYC(2)) dut (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_value(value), .i_dp(dp),
    .i_blank_lz(lz), .o_digitSelect(sel_a), .o_fnd_en(fen_a), .o_bcd(bcd_a),
    .o_dp(dp_a), .o_frame(frm_a));

  fnd_scan_controller #(.DIV(DIV), .BLANK_CYC(0)) dut0 (
    .i_clk(clk), .i_reset(rst), .i_en(en), .i_value(value), .i_dp(dp),
    .i_blank_lz(lz), .o_digitSelect(sel_b), .o_fnd_en(fen_b), .o_bcd(bcd_b),
    .o_dp(dp_b), .o_frame(frm_b));

  function automatic logic [15:0] pack_a();
    return 16'({sel_a, fen_a, bcd_a, dp_a, frm_a});
  endfunction

  function automatic logic [15:0] pack_b();
    return 16'({sel_b, fen_b, bcd_b, dp_b, frm_b});
  endfunction

  // Expected {sel, fnd_en, bcd, dp, frame} for a build with blanking gap b.
  function automatic logic [15:0] model_out(int b);
    int slot, pos;
    logic lit, sup;
    if (!m_active) return 16'({2'd0, 1'b0, m_val[3:0], m_dp[0], 1'b0});
    slot = (m_k / DIV) % 4;
    pos  = m_k % DIV;
    sup  = (slot > 0) && m_lz && ((m_val >> (4 * slot)) == 16'd0) && !m_dp[slot];
    lit  = (pos >= b) && !sup;
    return 16'({2'(slot), lit, 4'(m_val >> (4 * slot)), m_dp[slot],
                (m_k % (4 * DIV)) == 0});
  endfunction

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advances one clock, updates the model with the inputs seen at that edge, and checks both builds.
  task automatic step();
    @(posedge clk);
    if (rst) begin
      m_active = 0; m_k = 0; m_val = 16'd0; m_dp = 4'd0; m_lz = 1'b0;
    end else if (!en) begin
      m_active = 0; m_k = 0;
    end else if (!m_active) begin
      m_active = 1; m_k = 0; m_val = value; m_dp = dp; m_lz = lz;
    end else begin
      m_k++;
      if (m_k % (4 * DIV) == 0) begin
        m_val = value; m_dp = dp; m_lz = lz;
      end
    end
    #1;
    chk("model_b2", pack_a(), model_out(2));
    chk("model_b0", pack_b(), model_out(0));
  endtask

  initial begin
    logic [15:0] r;
    rst = 1'b1; en = 1'b0; value = 16'd0; dp = 4'd0; lz = 1'b0;
    m_active = 0; m_k = 0; m_val = 16'd0; m_dp = 4'd0; m_lz = 1'b0;

    // Reset state
    #2;
    chk("reset_state_b2", pack_a(), 16'd0);
    chk("reset_state_b0", pack_b(), 16'd0);
    step(); step();
    rst = 1'b0;
    step();
    chk("idle_after_reset", pack_a(), 16'd0);

    // Basic scan of 1234
    value = 16'h1234; en = 1'b1;
    for (int i = 0; i <= 32; i++) begin
      step();
      chk("scan_sel",   16'(sel_a), 16'((i / 8) % 4));
      chk("scan_bcd",   16'(bcd_a), 16'(4 - (i / 8) % 4));
      chk("scan_en",    16'(fen_a), 16'((i % 8) >= 2));
      chk("scan_frame", 16'(frm_a), 16'(i % 32 == 0));
      chk("scan_b0_en", 16'(fen_b), 16'd1);
    end

    // Mid-frame value change must wait for the next frame
    for (int k = 33; k <= 64; k++) begin
      step();
      if (k == 40) value = 16'h5678;
      if (k >= 40 && k < 64) chk("snap_old", 16'(bcd_a), 16'(4 - (k / 8) % 4));
    end
    chk("snap_new_frame", 16'(frm_a), 16'd1);
    chk("snap_new_bcd",   16'(bcd_a), 16'h8);
    for (int i = 0; i < 8; i++) step();
    chk("snap_new_d1", 16'(bcd_a), 16'h7);

    // Leading-zero suppression
    en = 1'b0; step();
    lz = 1'b1; value = 16'h0040; dp = 4'd0; en = 1'b1;
    for (int i = 0; i < 32; i++) begin
      step();
      if (i / 8 >= 2) chk("lz_dark", 16'(fen_a), 16'd0);
      if (i / 8 < 2 && i % 8 >= 2) chk("lz_lit", 16'(fen_a), 16'd1);
    end
    dp = 4'b1000;
    for (int i = 32; i < 64; i++) begin
      step();
      if ((i / 8) % 4 == 2) chk("lz_dark_d2", 16'(fen_a), 16'd0);
      if ((i / 8) % 4 == 3 && i % 8 >= 2)
        chk("lz_dp_d3", 16'({fen_a, bcd_a, dp_a}), 16'({1'b1, 4'h0, 1'b1}));
    end

    // Enable drop at digit 2, cnt 5
    en = 1'b0; step();
    value = 16'h9876; dp = 4'd0; lz = 1'b0; en = 1'b1;
    for (int i = 0; i <= 21; i++) step();
    chk("drop_pre_sel", 16'(sel_a), 16'd2);
    en = 1'b0; step();
    chk("drop_outs", 16'({fen_a, sel_a, frm_a}), 16'd0);
    value = 16'h4321; en = 1'b1; step();
    chk("reen_frame", 16'({frm_a, sel_a, bcd_a}), 16'({1'b1, 2'd0, 4'h1}));

    // Asynchronous reset while a digit is lit
    for (int i = 0; i < 5; i++) step();
    chk("pre_reset_lit", 16'(fen_a), 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("reset_async_b2", pack_a(), 16'd0);
    chk("reset_async_b0", pack_b(), 16'd0);
    en = 1'b0;
    step(); step();
    rst = 1'b0;
    step(); step();
    chk("idle_after_release", pack_a(), 16'd0);

    // Randomized traffic including non-BCD nibbles and enable drops
    en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      step();
      if ($urandom_range(0, 9) == 0) begin
        r = 16'($urandom);
        value = r >> (4 * $urandom_range(0, 4));
      end
      if ($urandom_range(0, 19) == 0) dp = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 29) == 0) lz = ~lz;
      if (en) begin
        if ($urandom_range(0, 99) == 0) en = 1'b0;
      end else if ($urandom_range(0, 3) == 0) begin
        en = 1'b1;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
